// File: rtl/load_store_unit.sv
// Load/store unit: turns an ALU effective address plus rs2 data into one B/H/W
// access on a req/ack data-memory port, returning the extended load value.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for lsu_start; request is checked and latched here
// ACCESS | mem_req held high until mem_ack or timeout
// DONE   | one-cycle completion pulse with error code, then back to IDLE
module load_store_unit #(
  parameter int OPERAND_LENGTH  = 32,
  parameter int MEM_ADDR_LENGTH = 12,
  parameter int MEM_TIMEOUT     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       lsu_start,
  input  logic                       lsu_we,
  input  logic [2:0]                 lsu_funct3,
  input  logic [OPERAND_LENGTH-1:0]  lsu_addr,
  input  logic [OPERAND_LENGTH-1:0]  lsu_store_data,
  output logic                       lsu_busy,
  output logic                       lsu_done,
  output logic [1:0]                 lsu_err_code,
  output logic [OPERAND_LENGTH-1:0]  lsu_load_data,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [MEM_ADDR_LENGTH-1:0] mem_addr,
  output logic [3:0]                 mem_be,
  output logic [31:0]                mem_wdata,
  input  logic [31:0]                mem_rdata,
  input  logic                       mem_ack
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                     r_state, w_state_nxt;
  logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
  logic                       r_busy, w_busy_nxt;
  logic                       r_done, w_done_nxt;
  logic [1:0]                 r_err, w_err_nxt;
  logic [OPERAND_LENGTH-1:0]  r_load, w_load_nxt;
  logic                       r_req, w_req_nxt;
  logic                       r_we, w_we_nxt;
  logic [MEM_ADDR_LENGTH-1:0] r_maddr, w_maddr_nxt;
  logic [3:0]                 r_be, w_be_nxt;
  logic [31:0]                r_wdata, w_wdata_nxt;
  logic [1:0]                 r_size, w_size_nxt;
  logic                       r_uns, w_uns_nxt;
  logic [1:0]                 r_off, w_off_nxt;

  logic        w_illegal;
  logic        w_misaligned;
  logic [3:0]  w_be_req;
  logic [31:0] w_wdata_req;
  logic [31:0] w_shift;
  logic [31:0] w_ext;
  logic        w_unused;

  assign w_unused = ^{lsu_addr[OPERAND_LENGTH-1:MEM_ADDR_LENGTH+2], w_shift[31:16]};

  // Loads accept 000/001/010/100/101; stores only 000/001/010.
  always_comb begin
    if (lsu_we)
      w_illegal = lsu_funct3[2] | (lsu_funct3[1:0] == 2'b11);
    else
      w_illegal = (lsu_funct3[1:0] == 2'b11) | (lsu_funct3[2:1] == 2'b11);
    w_misaligned = ((lsu_funct3[1:0] == 2'b01) && lsu_addr[0]) ||
                   ((lsu_funct3[1:0] == 2'b10) && (lsu_addr[1:0] != 2'b00));
  end

  always_comb begin
    w_be_req    = 4'b1111;
    w_wdata_req = lsu_store_data[31:0];
    case (lsu_funct3[1:0])
      2'b00: begin
        w_be_req    = 4'b0001 << lsu_addr[1:0];
        w_wdata_req = {4{lsu_store_data[7:0]}};
      end
      2'b01: begin
        w_be_req    = 4'b0011 << lsu_addr[1:0];
        w_wdata_req = {2{lsu_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction uses the offset/size captured at start, not live inputs.
  always_comb begin
    w_shift = mem_rdata >> {r_off, 3'b000};
    case (r_size)
      2'b00:   w_ext = r_uns ? {24'b0, w_shift[7:0]}  : {{24{w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_ext = r_uns ? {16'b0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_ext = mem_rdata;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;
    w_load_nxt  = r_load;
    w_req_nxt   = r_req;
    w_we_nxt    = r_we;
    w_maddr_nxt = r_maddr;
    w_be_nxt    = r_be;
    w_wdata_nxt = r_wdata;
    w_size_nxt  = r_size;
    w_uns_nxt   = r_uns;
    w_off_nxt   = r_off;
    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (lsu_start) begin
          w_busy_nxt = 1'b1;
          if (w_illegal || w_misaligned) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_err_nxt   = w_illegal ? ERR_ILLEGAL : ERR_MISALIGN;
          end else begin
            w_state_nxt = S_ACCESS;
            w_cnt_nxt   = '0;
            w_req_nxt   = 1'b1;
            w_we_nxt    = lsu_we;
            w_maddr_nxt = lsu_addr[MEM_ADDR_LENGTH+1:2];
            w_be_nxt    = w_be_req;
            w_wdata_nxt = w_wdata_req;
            w_size_nxt  = lsu_funct3[1:0];
            w_uns_nxt   = lsu_funct3[2];
            w_off_nxt   = lsu_addr[1:0];
          end
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_err_nxt   = ERR_OK;
          w_req_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
          w_cnt_nxt   = '0;
          if (!r_we)
            w_load_nxt = w_ext;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_err_nxt   = ERR_TIMEOUT;
          w_req_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_req_nxt   = 1'b0;
        w_we_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 2'b00;
      r_load  <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_maddr <= '0;
      r_be    <= 4'b0;
      r_wdata <= 32'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_off   <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_load  <= w_load_nxt;
      r_req   <= w_req_nxt;
      r_we    <= w_we_nxt;
      r_maddr <= w_maddr_nxt;
      r_be    <= w_be_nxt;
      r_wdata <= w_wdata_nxt;
      r_size  <= w_size_nxt;
      r_uns   <= w_uns_nxt;
      r_off   <= w_off_nxt;
    end
  end

  assign lsu_busy      = r_busy;
  assign lsu_done      = r_done;
  assign lsu_err_code  = r_err;
  assign lsu_load_data = r_load;
  assign mem_req       = r_req;
  assign mem_we        = r_we;
  assign mem_addr      = r_maddr;
  assign mem_be        = r_be;
  assign mem_wdata     = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit: table of single transactions plus
// hand-written reset-mid-access, stray-ack and timeout/start-ignore sequences.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        lsu_start;
  logic        lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_store_data;
  logic        lsu_busy;
  logic        lsu_done;
  logic [1:0]  lsu_err_code;
  logic [31:0] lsu_load_data;
  logic        mem_req;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_total = 0;
  int n_pass  = 0;

  load_store_unit #(
    .OPERAND_LENGTH (32),
    .MEM_ADDR_LENGTH(12),
    .MEM_TIMEOUT    (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lsu_start     (lsu_start),
    .lsu_we        (lsu_we),
    .lsu_funct3    (lsu_funct3),
    .lsu_addr      (lsu_addr),
    .lsu_store_data(lsu_store_data),
    .lsu_busy      (lsu_busy),
    .lsu_done      (lsu_done),
    .lsu_err_code  (lsu_err_code),
    .lsu_load_data (lsu_load_data),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [1:0]  err;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [11:0] maddr;
    logic [31:0] load;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    lsu_start      = 1'b1;
    lsu_we         = v.we;
    lsu_funct3     = v.f3;
    lsu_addr       = v.addr;
    lsu_store_data = v.sdata;
    mem_ack        = 1'b0;
    @(posedge clk); #1;
    lsu_start = 1'b0;
    if (v.err == 2'b00) begin
      chk($sformatf("v%0d_c1_req", idx),   {31'b0, mem_req},  32'd1);
      chk($sformatf("v%0d_c1_busy", idx),  {31'b0, lsu_busy}, 32'd1);
      chk($sformatf("v%0d_c1_done", idx),  {31'b0, lsu_done}, 32'd0);
      chk($sformatf("v%0d_we", idx),       {31'b0, mem_we},   {31'b0, v.we});
      chk($sformatf("v%0d_maddr", idx),    {20'b0, mem_addr}, {20'b0, v.maddr});
      chk($sformatf("v%0d_be", idx),       {28'b0, mem_be},   {28'b0, v.be});
      chk($sformatf("v%0d_wdata", idx),    mem_wdata,         v.wdata);
      mem_ack   = 1'b1;
      mem_rdata = v.rdata;
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      chk($sformatf("v%0d_c2_req", idx),   {31'b0, mem_req},  32'd0);
      chk($sformatf("v%0d_c2_we", idx),    {31'b0, mem_we},   32'd0);
    end else begin
      chk($sformatf("v%0d_err_req", idx),  {31'b0, mem_req},  32'd0);
    end
    chk($sformatf("v%0d_done", idx),       {31'b0, lsu_done}, 32'd1);
    chk($sformatf("v%0d_done_busy", idx),  {31'b0, lsu_busy}, 32'd1);
    chk($sformatf("v%0d_err", idx),        {30'b0, lsu_err_code}, {30'b0, v.err});
    chk($sformatf("v%0d_load", idx),       lsu_load_data,     v.load);
    @(posedge clk); #1;
    chk($sformatf("v%0d_after_done", idx), {31'b0, lsu_done}, 32'd0);
    chk($sformatf("v%0d_after_busy", idx), {31'b0, lsu_busy}, 32'd0);
    chk($sformatf("v%0d_after_err", idx),  {30'b0, lsu_err_code}, {30'b0, v.err});
  endtask

  initial begin
    int req_cycles;
    int done_cnt;
    int addr_bad;
    int done_seen;
    logic [1:0] last_err;

    //          we    f3      addr          sdata         rdata         err    be       wdata         maddr    load
    vecs[0]  = '{1'b1, 3'b010, 32'h00000104, 32'hDEADBEEF, 32'h00000000, 2'b00, 4'b1111, 32'hDEADBEEF, 12'h041, 32'h00000000};
    vecs[1]  = '{1'b0, 3'b010, 32'h00000104, 32'h00000000, 32'hDEADBEEF, 2'b00, 4'b1111, 32'h00000000, 12'h041, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 3'b000, 32'h00000003, 32'h00000000, 32'h80FF7F01, 2'b00, 4'b1000, 32'h00000000, 12'h000, 32'hFFFFFF80};
    vecs[3]  = '{1'b0, 3'b100, 32'h00000003, 32'h00000000, 32'h80FF7F01, 2'b00, 4'b1000, 32'h00000000, 12'h000, 32'h00000080};
    vecs[4]  = '{1'b0, 3'b000, 32'h00000001, 32'h00000000, 32'h80FF7F01, 2'b00, 4'b0010, 32'h00000000, 12'h000, 32'h0000007F};
    vecs[5]  = '{1'b1, 3'b001, 32'h00000022, 32'h1234ABCD, 32'h00000000, 2'b00, 4'b1100, 32'hABCDABCD, 12'h008, 32'h0000007F};
    vecs[6]  = '{1'b0, 3'b001, 32'h00000022, 32'h00000000, 32'h80010000, 2'b00, 4'b1100, 32'h00000000, 12'h008, 32'hFFFF8001};
    vecs[7]  = '{1'b0, 3'b101, 32'h00000022, 32'h00000000, 32'h80010000, 2'b00, 4'b1100, 32'h00000000, 12'h008, 32'h00008001};
    vecs[8]  = '{1'b0, 3'b010, 32'h00000102, 32'h00000000, 32'h00000000, 2'b01, 4'b0000, 32'h00000000, 12'h000, 32'h00008001};
    vecs[9]  = '{1'b1, 3'b100, 32'h00000010, 32'h11111111, 32'h00000000, 2'b10, 4'b0000, 32'h00000000, 12'h000, 32'h00008001};
    vecs[10] = '{1'b0, 3'b011, 32'h00000101, 32'h00000000, 32'h00000000, 2'b10, 4'b0000, 32'h00000000, 12'h000, 32'h00008001};
    vecs[11] = '{1'b0, 3'b001, 32'h00000103, 32'h00000000, 32'h00000000, 2'b01, 4'b0000, 32'h00000000, 12'h000, 32'h00008001};
    vecs[12] = '{1'b1, 3'b000, 32'h00000013, 32'h000000A5, 32'h00000000, 2'b00, 4'b1000, 32'hA5A5A5A5, 12'h004, 32'h00008001};
    vecs[13] = '{1'b0, 3'b010, 32'hFFFFF008, 32'h00000000, 32'h01234567, 2'b00, 4'b1111, 32'h00000000, 12'hC02, 32'h01234567};

    rst_n = 1'b0; lsu_start = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'b000;
    lsu_addr = 32'h0; lsu_store_data = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",  {31'b0, mem_req},  32'd0);
    chk("rst_busy", {31'b0, lsu_busy}, 32'd0);
    chk("rst_done", {31'b0, lsu_done}, 32'd0);
    chk("rst_err",  {30'b0, lsu_err_code}, 32'd0);
    chk("rst_load", lsu_load_data, 32'd0);
    chk("rst_bus",  {mem_be, mem_addr, 15'b0, mem_we}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Reset while an access is in flight.
    @(negedge clk);
    lsu_start = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h00000040;
    @(posedge clk); #1;
    lsu_start = 1'b0;
    @(posedge clk); #1;
    chk("midrst_req_before", {31'b0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_req_async", {31'b0, mem_req}, 32'd0);
    chk("midrst_busy", {31'b0, lsu_busy}, 32'd0);
    chk("midrst_bus",  {mem_be, mem_addr, 15'b0, mem_we}, 32'd0);
    done_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (lsu_done) done_seen++;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (lsu_done) done_seen++;
    end
    chk("midrst_no_done", done_seen, 32'd0);
    chk("midrst_load", lsu_load_data, 32'd0);

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Ack while idle must not disturb anything.
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("stray_ack_done", {31'b0, lsu_done}, 32'd0);
    chk("stray_ack_busy", {31'b0, lsu_busy}, 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("stray_ack_load", lsu_load_data, 32'h01234567);

    // Timeout, with start pulses during ACCESS and DONE that must be ignored.
    @(negedge clk);
    lsu_start = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h00000200;
    req_cycles = 0; done_cnt = 0; addr_bad = 0; last_err = 2'b00;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lsu_start = 1'b0;
      lsu_we = 1'b1; lsu_funct3 = 3'b010; lsu_addr = 32'h00000300; lsu_store_data = 32'h55AA55AA;
      if (mem_req) begin
        req_cycles++;
        if (mem_addr != 12'h080 || mem_we != 1'b0) addr_bad++;
      end
      if (lsu_done) begin
        done_cnt++;
        last_err = lsu_err_code;
        lsu_start = 1'b1;
      end
      if (i == 4 || i == 9) lsu_start = 1'b1;
    end
    lsu_start = 1'b0;
    chk("to_req_cycles", req_cycles, 32'd16);
    chk("to_done_count", done_cnt, 32'd1);
    chk("to_err", {30'b0, last_err}, 32'd3);
    chk("to_bus_stable", addr_bad, 32'd0);
    chk("to_busy_after", {31'b0, lsu_busy}, 32'd0);
    chk("to_load", lsu_load_data, 32'h01234567);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
